// File: rtl/ram_access_pkg.sv
// Shared encodings and the command legality check for the word-RAM access master.
package ram_access_pkg;

  localparam int OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    WT_NONE = 2'b00,
    WT_BYTE = 2'b01,
    WT_HALF = 2'b10,
    WT_WORD = 2'b11
  } write_type_e;

  typedef enum logic [2:0] {
    RT_NONE        = 3'b000,
    RT_BYTE        = 3'b001,
    RT_HALF        = 3'b010,
    RT_WORD        = 3'b011,
    RT_BYTE_SIGNED = 3'b101,
    RT_HALF_SIGNED = 3'b110
  } read_type_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  // Misaligned halves/words, mixed load+store, and the two unused read codes are rejected.
  function automatic logic command_error(input logic [1:0] write_type,
                                         input logic [2:0] read_type,
                                         input logic [OFFSET_BITS-1:0] offset);
    logic is_half;
    logic is_word;
    is_half = (write_type == WT_HALF) || (read_type == RT_HALF) || (read_type == RT_HALF_SIGNED);
    is_word = (write_type == WT_WORD) || (read_type == RT_WORD);
    return (is_half && offset[0]) ||
           (is_word && (offset != 2'b00)) ||
           ((write_type != WT_NONE) && (read_type != RT_NONE)) ||
           (read_type == 3'b100) || (read_type == 3'b111);
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Combinational lane logic: load extract with optional sign extension, and sub-word store merge.
module ram_lane_align
  import ram_access_pkg::*;
(
  input  logic [OFFSET_BITS-1:0] offset,
  input  logic [2:0]             read_type,
  input  logic [1:0]             write_type,
  input  logic [31:0]            word,
  input  logic [31:0]            write_data,
  output logic [31:0]            load_data,
  output logic [31:0]            merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (read_type)
      RT_BYTE:        load_data = {24'h0, byte_lane};
      RT_BYTE_SIGNED: load_data = {{24{byte_lane[7]}}, byte_lane};
      RT_HALF:        load_data = {16'h0, half_lane};
      RT_HALF_SIGNED: load_data = {{16{half_lane[15]}}, half_lane};
      RT_WORD:        load_data = word;
      default:        load_data = '0;
    endcase

    // Only the addressed lane(s) change; the rest of the word is preserved from the RAM read.
    merged = word;
    case (write_type)
      WT_BYTE: merged[{offset, 3'b000} +: 8] = write_data[7:0];
      WT_HALF: begin
        if (offset[1]) merged[31:16] = write_data[15:0];
        else           merged[15:0]  = write_data[15:0];
      end
      WT_WORD: merged = write_data;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/ram_access_master.sv
// Load/store initiator for the combinational-read word RAM; sub-word stores use read-modify-write.
module ram_access_master
  import ram_access_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDRESS_BITWIDTH-1:0]   cmd_address,
  input  logic [1:0]                    cmd_write_type,
  input  logic [2:0]                    cmd_read_type,
  input  logic [DATA_BITWIDTH-1:0]      cmd_write_data,
  output logic                          rsp_valid,
  output logic [DATA_BITWIDTH-1:0]      rsp_data,
  output logic                          rsp_error,
  output logic                          ram_write_enable,
  output logic [ADDRESS_BITWIDTH-3:0]   ram_address,
  output logic [DATA_BITWIDTH-1:0]      ram_data_out,
  input  logic [DATA_BITWIDTH-1:0]      ram_data_in
);

  state_e                 state;
  logic [OFFSET_BITS-1:0] offset_q;
  logic [1:0]             write_type_q;
  logic [2:0]             read_type_q;
  logic [31:0]            write_data_q;

  logic                   cmd_err;
  logic                   cmd_noop;
  logic [31:0]            load_data;
  logic [31:0]            merged;

  assign cmd_err  = command_error(cmd_write_type, cmd_read_type, cmd_address[OFFSET_BITS-1:0]);
  assign cmd_noop = (cmd_write_type == WT_NONE) && (cmd_read_type == RT_NONE);

  ram_lane_align u_lane_align (
    .offset     (offset_q),
    .read_type  (read_type_q),
    .write_type (write_type_q),
    .word       (ram_data_in),
    .write_data (write_data_q),
    .load_data  (load_data),
    .merged     (merged)
  );

  // RAM-side outputs are set on the edge entering ACCESS so they are stable for the whole access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      offset_q         <= '0;
      write_type_q     <= '0;
      read_type_q      <= '0;
      write_data_q     <= '0;
      cmd_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_error        <= 1'b0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            offset_q     <= cmd_address[OFFSET_BITS-1:0];
            write_type_q <= cmd_write_type;
            read_type_q  <= cmd_read_type;
            write_data_q <= cmd_write_data;
            cmd_ready    <= 1'b0;
            if (cmd_err || cmd_noop) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_error <= cmd_err;
            end else begin
              state            <= ACCESS;
              ram_address      <= cmd_address[ADDRESS_BITWIDTH-1:OFFSET_BITS];
              ram_write_enable <= (cmd_write_type == WT_WORD);
              ram_data_out     <= cmd_write_data;
            end
          end
        end
        ACCESS: begin
          if (write_type_q == WT_NONE || write_type_q == WT_WORD) begin
            state            <= RESP;
            ram_write_enable <= 1'b0;
            rsp_valid        <= 1'b1;
            rsp_data         <= (write_type_q == WT_NONE) ? load_data : '0;
            rsp_error        <= 1'b0;
          end else begin
            state            <= WRITE;
            ram_write_enable <= 1'b1;
            ram_data_out     <= merged;
          end
        end
        WRITE: begin
          state            <= RESP;
          ram_write_enable <= 1'b0;
          rsp_valid        <= 1'b1;
          rsp_data         <= '0;
          rsp_error        <= 1'b0;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a behavioural word RAM and a response scoreboard.
module tb_ram_access_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_address;
  logic [1:0]  cmd_write_type;
  logic [2:0]  cmd_read_type;
  logic [31:0] cmd_write_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        ram_write_enable;
  logic [13:0] ram_address;
  logic [31:0] ram_data_out;
  logic [31:0] ram_data_in;

  logic [31:0] mem [0:16383];
  int          write_count;
  int          errors;
  int          checks;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          writes;
  } expect_t;

  expect_t scoreboard[$];

  ram_access_master #(
    .ADDRESS_BITWIDTH (16),
    .DATA_BITWIDTH    (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_address      (cmd_address),
    .cmd_write_type   (cmd_write_type),
    .cmd_read_type    (cmd_read_type),
    .cmd_write_data   (cmd_write_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_error        (rsp_error),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_out     (ram_data_out),
    .ram_data_in      (ram_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data_in = mem[ram_address];

  always @(posedge clk) begin
    if (ram_write_enable) begin
      mem[ram_address] <= ram_data_out;
      write_count      <= write_count + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issues one command, queues its expected response, then waits (bounded) for rsp_valid and scores it.
  task automatic apply_stimulus(input string tag, input logic [15:0] address, input logic [1:0] wt,
                                input logic [2:0] rt, input logic [31:0] wdata,
                                input logic [31:0] exp_data, input logic exp_err,
                                input int exp_lat, input int exp_writes);
    expect_t e;
    expect_t got;
    int      start_writes;
    int      lat;
    @(negedge clk);
    check_output({tag, "/ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid      = 1'b1;
    cmd_address    = address;
    cmd_write_type = wt;
    cmd_read_type  = rt;
    cmd_write_data = wdata;
    e.tag = tag; e.data = exp_data; e.err = exp_err; e.lat = exp_lat; e.writes = exp_writes;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    start_writes = write_count;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 8);
    got = scoreboard.pop_front();
    check_output({got.tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_output({got.tag, "/latency"}, 32'(lat), 32'(got.lat));
    check_output({got.tag, "/rsp_data"}, rsp_data, got.data);
    check_output({got.tag, "/rsp_error"}, 32'(rsp_error), 32'(got.err));
    check_output({got.tag, "/ram_writes"}, 32'(write_count - start_writes), 32'(got.writes));
    @(negedge clk);
    check_output({got.tag, "/pulse_end"}, 32'(rsp_valid), 32'd0);
    check_output({got.tag, "/rsp_hold"}, rsp_data, got.data);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int start_writes;
    int pulses;
    errors         = 0;
    checks         = 0;
    write_count    = 0;
    rst_n          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_address    = '0;
    cmd_write_type = '0;
    cmd_read_type  = '0;
    cmd_write_data = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

    repeat (2) @(negedge clk);
    check_output("reset/cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset/rsp_data", rsp_data, 32'h0);
    check_output("reset/we", 32'(ram_write_enable), 32'd0);
    check_output("reset/ram_address", 32'(ram_address), 32'd0);
    rst_n = 1'b1;

    apply_stimulus("word_wr", 16'h0010, 2'b11, 3'b000, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
    check_output("mem4_deadbeef", mem[4], 32'hDEADBEEF);
    apply_stimulus("word_rd", 16'h0010, 2'b00, 3'b011, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    apply_stimulus("word_wr2", 16'h0010, 2'b11, 3'b000, 32'h11223344, 32'h0, 1'b0, 2, 1);
    apply_stimulus("byte_wr", 16'h0011, 2'b01, 3'b000, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1);
    check_output("mem4_byte", mem[4], 32'h1122AA44);
    apply_stimulus("byte_rd_s", 16'h0011, 2'b00, 3'b101, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
    apply_stimulus("byte_rd_u", 16'h0011, 2'b00, 3'b001, 32'h0, 32'h000000AA, 1'b0, 2, 0);
    apply_stimulus("half_wr", 16'h0012, 2'b10, 3'b000, 32'h00008001, 32'h0, 1'b0, 3, 1);
    check_output("mem4_half", mem[4], 32'h8001AA44);
    apply_stimulus("half_rd_s", 16'h0012, 2'b00, 3'b110, 32'h0, 32'hFFFF8001, 1'b0, 2, 0);
    apply_stimulus("half_rd_u", 16'h0012, 2'b00, 3'b010, 32'h0, 32'h00008001, 1'b0, 2, 0);
    apply_stimulus("half_rd_lo_s", 16'h0010, 2'b00, 3'b110, 32'h0, 32'hFFFFAA44, 1'b0, 2, 0);
    apply_stimulus("byte_rd_b0", 16'h0010, 2'b00, 3'b101, 32'h0, 32'h00000044, 1'b0, 2, 0);
    apply_stimulus("byte_rd_b3", 16'h0013, 2'b00, 3'b001, 32'h0, 32'h00000080, 1'b0, 2, 0);

    apply_stimulus("word_rd_misal", 16'h0013, 2'b00, 3'b011, 32'h0, 32'h0, 1'b1, 1, 0);
    apply_stimulus("half_wr_misal", 16'h0001, 2'b10, 3'b000, 32'h0000BEEF, 32'h0, 1'b1, 1, 0);
    apply_stimulus("both_types", 16'h0010, 2'b11, 3'b011, 32'h12345678, 32'h0, 1'b1, 1, 0);
    apply_stimulus("rd_type_100", 16'h0010, 2'b00, 3'b100, 32'h0, 32'h0, 1'b1, 1, 0);
    apply_stimulus("rd_type_111", 16'h0010, 2'b00, 3'b111, 32'h0, 32'h0, 1'b1, 1, 0);
    apply_stimulus("noop", 16'h0010, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 1, 0);
    check_output("mem4_after_errors", mem[4], 32'h8001AA44);
    check_output("mem0_after_errors", mem[0], 32'h0);

    apply_stimulus("byte_wr_lane0", 16'h0020, 2'b01, 3'b000, 32'h12345678, 32'h0, 1'b0, 3, 1);
    check_output("mem8_lane0", mem[8], 32'h00000078);

    // Abort a byte store while it is in ACCESS: nothing may reach the RAM.
    @(negedge clk);
    cmd_valid      = 1'b1;
    cmd_address    = 16'h0011;
    cmd_write_type = 2'b01;
    cmd_read_type  = 3'b000;
    cmd_write_data = 32'h00000055;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    start_writes = write_count;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort/we", 32'(ram_write_enable), 32'd0);
    check_output("abort/cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("abort/rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("abort/rsp_data", rsp_data, 32'h0);
    check_output("abort/rsp_error", 32'(rsp_error), 32'd0);
    check_output("abort/ram_address", 32'(ram_address), 32'd0);
    check_output("abort/ram_data_out", ram_data_out, 32'h0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check_output("abort/no_response", 32'(pulses), 32'd0);
    check_output("abort/no_write", 32'(write_count - start_writes), 32'd0);
    check_output("abort/mem4", mem[4], 32'h8001AA44);
    check_output("abort/ready_after", 32'(cmd_ready), 32'd1);

    apply_stimulus("post_reset_rd", 16'h0010, 2'b00, 3'b011, 32'h0, 32'h8001AA44, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
